// File: rtl/branch_resolver.sv
// branch_resolver: evaluates issued conditional branches, queues the outcomes
// in program order and broadcasts them one per CDB grant as
// {cdb_addr = branch PC, cdb_val[0] = taken}.
// Optional feature macro BR_TARGET_EN: adds issue_imm / cdb_target and stores
// the branch target (pc + imm) alongside each queued outcome.
module branch_resolver #(
  parameter int QUEUE_DEPTH = 4,
  parameter int QUEUE_W     = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_pc,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [2:0]  issue_funct3,
`ifdef BR_TARGET_EN
  input  logic [31:0] issue_imm,
  output logic [31:0] cdb_target,
`endif
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic        cdb_active,
  output logic [31:0] cdb_addr,
  output logic [31:0] cdb_val
);

  localparam logic [QUEUE_W:0]   FULL_COUNT = (QUEUE_W + 1)'(QUEUE_DEPTH);
  localparam logic [QUEUE_W-1:0] PTR_ONE    = QUEUE_W'(1);
  localparam logic [QUEUE_W:0]   CNT_ONE    = (QUEUE_W + 1)'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t state, state_next;

  logic [QUEUE_W-1:0] front, rear;
  logic [QUEUE_W:0]   count, count_next;
  logic [QUEUE_W-1:0] front_next, rear_next;

  logic [31:0] pc_q    [QUEUE_DEPTH];
  logic        taken_q [QUEUE_DEPTH];
`ifdef BR_TARGET_EN
  logic [31:0] target_q [QUEUE_DEPTH];
  logic [31:0] target_reg;
`endif

  logic        active_reg;
  logic [31:0] addr_reg;
  logic        taken_reg;

  logic push_go;
  logic pop_go;
  logic flush_go;
  logic issue_taken;

  // Branch comparison for the RV32 conditional branch encodings
  function automatic logic eval_taken(input logic [2:0]  f3,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic r;
    r = 1'b0;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = ($signed(a) <  $signed(b));
      3'b101:  r = ($signed(a) >= $signed(b));
      3'b110:  r = (a <  b);
      3'b111:  r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Handshake decode: flush (with ready) overrides both push and pop
  always_comb begin
    issue_ready = (count != FULL_COUNT);
    cdb_req     = (state == PENDING) && !flush_in;
    flush_go    = rdy_in && flush_in;
    push_go     = issue_valid && issue_ready && rdy_in && !flush_in;
    pop_go      = cdb_req && cdb_grant && rdy_in;
    issue_taken = eval_taken(issue_funct3, issue_rs1, issue_rs2);
  end

  // Next pointer/count/state; state mirrors count != 0
  always_comb begin
    front_next = front;
    rear_next  = rear;
    count_next = count;
    state_next = state;
    if (flush_go) begin
      front_next = '0;
      rear_next  = '0;
      count_next = '0;
      state_next = IDLE;
    end else if (rdy_in) begin
      if (push_go) begin
        rear_next = rear + PTR_ONE;
      end
      if (pop_go) begin
        front_next = front + PTR_ONE;
      end
      case ({push_go, pop_go})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
      state_next = (count_next != '0) ? PENDING : IDLE;
    end
  end

  // Control state: pointers, occupancy and FSM state
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      front <= '0;
      rear  <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      front <= front_next;
      rear  <= rear_next;
      count <= count_next;
      state <= state_next;
    end
  end

  // Queue storage: written at rear on an accepted issue
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]    <= '0;
        taken_q[i] <= 1'b0;
`ifdef BR_TARGET_EN
        target_q[i] <= '0;
`endif
      end
    end else if (push_go) begin
      pc_q[rear]    <= issue_pc;
      taken_q[rear] <= issue_taken;
`ifdef BR_TARGET_EN
      target_q[rear] <= issue_pc + issue_imm;
`endif
    end
  end

  // Broadcast register: one cycle of cdb_active per successful pop
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_reg <= 1'b0;
      addr_reg   <= '0;
      taken_reg  <= 1'b0;
`ifdef BR_TARGET_EN
      target_reg <= '0;
`endif
    end else if (rdy_in) begin
      if (pop_go) begin
        active_reg <= 1'b1;
        addr_reg   <= pc_q[front];
        taken_reg  <= taken_q[front];
`ifdef BR_TARGET_EN
        target_reg <= target_q[front];
`endif
      end else begin
        active_reg <= 1'b0;
`ifdef BR_TARGET_EN
        target_reg <= '0;
`endif
      end
    end
  end

  // Registered broadcast outputs; addr/val keep the last broadcast value
  always_comb begin
    cdb_active = active_reg;
    cdb_addr   = addr_reg;
    cdb_val    = {31'b0, taken_reg};
`ifdef BR_TARGET_EN
    cdb_target = target_reg;
`endif
  end

endmodule
